// File: rtl/press_classifier_ip_pkg.sv
// press_classifier_ip_pkg: shared state encoding and counter-width helper for the press classifier.
package press_classifier_ip_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b);
  endfunction

endpackage

// File: rtl/press_timer.sv
// press_timer: clear/enable cycle counter with terminal-count compare.
module press_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;

  assign done = cnt == term;

endmodule

// File: rtl/press_classifier_ip.sv
// press_classifier_ip: classifies debounced button activity into short, long and double-click pulses.
// Double-click detection (GAP/PRESS2, double_o) is built only with PRESS_CLASSIFIER_DOUBLE_EN defined.
module press_classifier_ip
  import press_classifier_ip_pkg::*;
#(
  parameter int LongPressCycles = 50_000_000,
  parameter int GapCycles       = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic held_o,
  output logic busy_o
);

`ifdef PRESS_CLASSIFIER_DOUBLE_EN
  localparam int W = cnt_width(LongPressCycles, GapCycles);
`else
  localparam int W = cnt_width(LongPressCycles, LongPressCycles);
`endif
  // PRESS1 is entered on the edge that already samples the first high level,
  // so its terminal is one lower to make long_o land after edge LongPressCycles-1.
  localparam logic [W-1:0] LONG_TERM = W'(LongPressCycles - 2);
  localparam logic [W-1:0] GAP_TERM  = W'(GapCycles - 1);

  state_t state;
  logic   lvl_q, rise, fall, done, clr, en;

  assign rise = level_i & ~lvl_q;
  assign fall = ~level_i & lvl_q;
  assign en   = state == PRESS1 || state == GAP;
  assign clr  = !en || (state == PRESS1 && fall);

  press_timer #(.W(W)) u_timer (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .clr  (clr),
    .en   (en),
    .term (state == GAP ? GAP_TERM : LONG_TERM),
    .done (done)
  );

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state    <= IDLE;
      lvl_q    <= 1'b1;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
      held_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      lvl_q    <= level_i;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          state  <= PRESS1;
          busy_o <= 1'b1;
        end
        PRESS1: if (fall) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
          state <= GAP;
`else
          state   <= IDLE;
          short_o <= 1'b1;
          busy_o  <= 1'b0;
`endif
        end else if (done) begin
          state  <= LONG_HELD;
          long_o <= 1'b1;
          held_o <= 1'b1;
        end
        LONG_HELD: if (fall) begin
          state  <= IDLE;
          held_o <= 1'b0;
          busy_o <= 1'b0;
        end
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        GAP: if (rise) begin
          state    <= PRESS2;
          double_o <= 1'b1;
        end else if (done) begin
          state   <= IDLE;
          short_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        PRESS2: if (fall) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
`endif
        default: begin
          state  <= IDLE;
          held_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end

endmodule

// File: tb/tb_press_classifier_ip.sv
// tb_press_classifier_ip: scoreboard bench; a gesture-level model over the sampled level sequence
// predicts events, busy and held, and a monitor compares them against the DUT every cycle.
module tb_press_classifier_ip;

  localparam int L    = 8;
  localparam int G    = 4;
  localparam int TAIL = L + G + 4;

  typedef struct {
    int kind;
    int edge_n;
  } ev_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic level_i = 1'b0;
  logic short_o, long_o, double_o, held_o, busy_o;

  int    checks = 0;
  int    errors = 0;
  int    cur_edge = 0;
  bit    mon_en = 1'b0;
  string ep_name = "init";
  bit    lev[$];
  bit    exp_busy[$];
  bit    exp_held[$];
  ev_t   exp_q[$];

  press_classifier_ip #(.LongPressCycles(L), .GapCycles(G)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .level_i (level_i),
    .short_o (short_o),
    .long_o  (long_o),
    .double_o(double_o),
    .held_o  (held_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic add(input bit v, input int n);
    for (int j = 0; j < n; j++) lev.push_back(v);
  endtask

  task automatic mark(input int a, input int b, input bit is_held);
    for (int j = a; j < b && j < lev.size(); j++)
      if (is_held) exp_held[j] = 1'b1;
      else exp_busy[j] = 1'b1;
  endtask

  task automatic push_ev(input int kind, input int edge_n);
    ev_t ev;
    ev.kind   = kind;
    ev.edge_n = edge_n;
    exp_q.push_back(ev);
  endtask

  // Gesture rules applied to whole runs of high/low samples; index k is the level sampled at edge k.
  task automatic build_expect();
    int n, i, s, e;
    n = lev.size();
    exp_busy.delete();
    exp_held.delete();
    for (int j = 0; j < n; j++) begin
      exp_busy.push_back(1'b0);
      exp_held.push_back(1'b0);
    end
    i = 0;
    while (i < n && lev[i]) i++;
    while (i < n) begin
      if (!lev[i]) begin
        i++;
        continue;
      end
      s = i;
      e = s;
      while (e < n && lev[e]) e++;
      if (e - s >= L) begin
        push_ev(2, s + L - 1);
        mark(s, e, 1'b0);
        mark(s + L - 1, e, 1'b1);
        i = e;
      end else begin
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
        int r, e2;
        r = e;
        while (r < n && !lev[r]) r++;
        if (r < n && r - e <= G) begin
          push_ev(3, r);
          e2 = r;
          while (e2 < n && lev[e2]) e2++;
          mark(s, e2, 1'b0);
          i = e2;
        end else begin
          push_ev(1, e + G);
          mark(s, e + G, 1'b0);
          i = e + G;
        end
`else
        push_ev(1, e);
        mark(s, e, 1'b0);
        i = e;
`endif
      end
    end
  endtask

  task automatic check_zero(input string what);
    checks++;
    if ({short_o, long_o, double_o, held_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL %s %s outputs got %b exp 00000", ep_name, what,
               {short_o, long_o, double_o, held_o, busy_o});
    end
  endtask

  task automatic run_episode(input string name);
    ep_name = name;
    exp_q.delete();
    build_expect();
    @(posedge clk);
    #3 rst_ni = 1'b0;
    level_i = lev[0];
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_ni   = 1'b1;
    level_i  = lev[0];
    cur_edge = 0;
    mon_en   = 1'b1;
    for (int k = 1; k < lev.size(); k++) begin
      @(negedge clk);
      level_i  = lev[k];
      cur_edge = k;
    end
    @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing events got 0 exp %0d (next kind %0d edge %0d)", name,
               exp_q.size(), exp_q[0].kind, exp_q[0].edge_n);
    end
    lev.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      checks++;
      if (busy_o !== exp_busy[cur_edge]) begin
        errors++;
        $display("FAIL %s busy edge %0d got %b exp %b", ep_name, cur_edge, busy_o, exp_busy[cur_edge]);
      end
      checks++;
      if (held_o !== exp_held[cur_edge]) begin
        errors++;
        $display("FAIL %s held edge %0d got %b exp %b", ep_name, cur_edge, held_o, exp_held[cur_edge]);
      end
      if (short_o || long_o || double_o) begin
        int   kind;
        ev_t  ev;
        kind = short_o ? 1 : long_o ? 2 : 3;
        checks++;
        if ($countones({short_o, long_o, double_o}) > 1) begin
          errors++;
          $display("FAIL %s onehot edge %0d got %b exp one pulse", ep_name, cur_edge,
                   {short_o, long_o, double_o});
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected event kind %0d edge %0d exp none", ep_name, kind, cur_edge);
        end else begin
          ev = exp_q.pop_front();
          if (ev.kind != kind || ev.edge_n != cur_edge) begin
            errors++;
            $display("FAIL %s event got kind %0d edge %0d exp kind %0d edge %0d", ep_name, kind,
                     cur_edge, ev.kind, ev.edge_n);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("power-on");

    add(0, 2); add(1, 3); add(0, TAIL);
    run_episode("short");
    add(0, 2); add(1, 12); add(0, TAIL);
    run_episode("long");
    add(0, 2); add(1, 3); add(0, 2); add(1, 3); add(0, TAIL);
    run_episode("double");
    add(0, 2); add(1, 7); add(0, TAIL);
    run_episode("release_at_cnt7");
    add(0, 2); add(1, 8); add(0, TAIL);
    run_episode("long_exact");
    add(0, 2); add(1, 3); add(0, 4); add(1, 3); add(0, TAIL);
    run_episode("gap_boundary");
    add(0, 2); add(1, 3); add(0, 5); add(1, 3); add(0, TAIL);
    run_episode("gap_too_long");

    // Mid-PRESS1 asynchronous reset, then the level stays high through reset release.
    ep_name = "mid_press";
    @(negedge clk);
    level_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_press busy before reset got %b exp 1", busy_o);
    end
    add(1, 5); add(0, 2); add(1, 3); add(0, TAIL);
    run_episode("hold_through_reset");

    for (int ep = 0; ep < 20; ep++) begin
      add(0, $urandom_range(0, 2));
      for (int g = 0; g < $urandom_range(1, 4); g++) begin
        add(1, $urandom_range(1, 12));
        add(0, $urandom_range(1, 7));
      end
      add(0, TAIL);
      run_episode($sformatf("random_%0d", ep));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
